// File: rtl/midi_note_decoder.sv
// rtl/midi_note_decoder.sv - MIDI byte-stream parser driving square, triangle and drum voices
//
// Ports:
//   clk       system clock
//   reset_n   synchronous active-low reset
//   rx_data   received MIDI byte, qualified by rx_valid
//   rx_valid  one-cycle strobe per received byte
//   sq_freq   square voice frequency in Hz (never 0)
//   sq_on     square voice gate
//   tri_freq  triangle voice frequency in Hz (never 0)
//   tri_on    triangle voice gate
//   beat      drum pulse, BEAT_CYCLES clocks long
module midi_note_decoder #(
  parameter int SQ_CH       = 0,
  parameter int TRI_CH      = 1,
  parameter int DRUM_CH     = 9,
  parameter int BEAT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] sq_freq,
  output logic        sq_on,
  output logic [11:0] tri_freq,
  output logic        tri_on,
  output logic        beat
);

  localparam logic [3:0] SQ_CH_L   = 4'(SQ_CH);
  localparam logic [3:0] TRI_CH_L  = 4'(TRI_CH);
  localparam logic [3:0] DRUM_CH_L = 4'(DRUM_CH);
  // The counter holds the remaining cycles after the first high cycle.
  localparam int BEAT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [11:0] HZ_A4 = 12'd440;
  localparam logic [6:0]  NOTE_A4 = 7'd69;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  // Equal-tempered note table, A4 = 440 Hz, rounded to the nearest Hz.
  function automatic logic [11:0] note_hz(input logic [6:0] n);
    logic [11:0] hz;
    case (n)
      7'd0:   hz = 12'd8;    7'd1:   hz = 12'd9;    7'd2:   hz = 12'd9;
      7'd3:   hz = 12'd10;   7'd4:   hz = 12'd10;   7'd5:   hz = 12'd11;
      7'd6:   hz = 12'd12;   7'd7:   hz = 12'd12;   7'd8:   hz = 12'd13;
      7'd9:   hz = 12'd14;   7'd10:  hz = 12'd15;   7'd11:  hz = 12'd15;
      7'd12:  hz = 12'd16;   7'd13:  hz = 12'd17;   7'd14:  hz = 12'd18;
      7'd15:  hz = 12'd19;   7'd16:  hz = 12'd21;   7'd17:  hz = 12'd22;
      7'd18:  hz = 12'd23;   7'd19:  hz = 12'd24;   7'd20:  hz = 12'd26;
      7'd21:  hz = 12'd28;   7'd22:  hz = 12'd29;   7'd23:  hz = 12'd31;
      7'd24:  hz = 12'd33;   7'd25:  hz = 12'd35;   7'd26:  hz = 12'd37;
      7'd27:  hz = 12'd39;   7'd28:  hz = 12'd41;   7'd29:  hz = 12'd44;
      7'd30:  hz = 12'd46;   7'd31:  hz = 12'd49;   7'd32:  hz = 12'd52;
      7'd33:  hz = 12'd55;   7'd34:  hz = 12'd58;   7'd35:  hz = 12'd62;
      7'd36:  hz = 12'd65;   7'd37:  hz = 12'd69;   7'd38:  hz = 12'd73;
      7'd39:  hz = 12'd78;   7'd40:  hz = 12'd82;   7'd41:  hz = 12'd87;
      7'd42:  hz = 12'd92;   7'd43:  hz = 12'd98;   7'd44:  hz = 12'd104;
      7'd45:  hz = 12'd110;  7'd46:  hz = 12'd117;  7'd47:  hz = 12'd123;
      7'd48:  hz = 12'd131;  7'd49:  hz = 12'd139;  7'd50:  hz = 12'd147;
      7'd51:  hz = 12'd156;  7'd52:  hz = 12'd165;  7'd53:  hz = 12'd175;
      7'd54:  hz = 12'd185;  7'd55:  hz = 12'd196;  7'd56:  hz = 12'd208;
      7'd57:  hz = 12'd220;  7'd58:  hz = 12'd233;  7'd59:  hz = 12'd247;
      7'd60:  hz = 12'd262;  7'd61:  hz = 12'd277;  7'd62:  hz = 12'd294;
      7'd63:  hz = 12'd311;  7'd64:  hz = 12'd330;  7'd65:  hz = 12'd349;
      7'd66:  hz = 12'd370;  7'd67:  hz = 12'd392;  7'd68:  hz = 12'd415;
      7'd69:  hz = 12'd440;  7'd70:  hz = 12'd466;  7'd71:  hz = 12'd494;
      7'd72:  hz = 12'd523;  7'd73:  hz = 12'd554;  7'd74:  hz = 12'd587;
      7'd75:  hz = 12'd622;  7'd76:  hz = 12'd659;  7'd77:  hz = 12'd698;
      7'd78:  hz = 12'd740;  7'd79:  hz = 12'd784;  7'd80:  hz = 12'd831;
      7'd81:  hz = 12'd880;  7'd82:  hz = 12'd932;  7'd83:  hz = 12'd988;
      7'd84:  hz = 12'd1047; 7'd85:  hz = 12'd1109; 7'd86:  hz = 12'd1175;
      7'd87:  hz = 12'd1245; 7'd88:  hz = 12'd1319; 7'd89:  hz = 12'd1397;
      7'd90:  hz = 12'd1480; 7'd91:  hz = 12'd1568; 7'd92:  hz = 12'd1661;
      7'd93:  hz = 12'd1760; 7'd94:  hz = 12'd1865; 7'd95:  hz = 12'd1976;
      7'd96:  hz = 12'd2093; 7'd97:  hz = 12'd2217; 7'd98:  hz = 12'd2349;
      7'd99:  hz = 12'd2489; 7'd100: hz = 12'd2637; 7'd101: hz = 12'd2794;
      7'd102: hz = 12'd2960; 7'd103: hz = 12'd3136; 7'd104: hz = 12'd3322;
      7'd105: hz = 12'd3520; 7'd106: hz = 12'd3729; 7'd107: hz = 12'd3951;
      // Unplayable notes never reach the voices; keep a safe nonzero value.
      default: hz = HZ_A4;
    endcase
    return hz;
  endfunction

  // Parser state
  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  d1_q, d1_d;

  // Execute stage: decoded message plus registered ROM read
  logic        ev_sq_on_q, ev_sq_on_d;
  logic        ev_sq_off_q, ev_sq_off_d;
  logic        ev_sq_all_q, ev_sq_all_d;
  logic        ev_tri_on_q, ev_tri_on_d;
  logic        ev_tri_off_q, ev_tri_off_d;
  logic        ev_tri_all_q, ev_tri_all_d;
  logic        ev_drum_q, ev_drum_d;
  logic [6:0]  ev_note_q, ev_note_d;
  logic [11:0] ev_hz_q, ev_hz_d;

  // Voice state
  logic [11:0] sq_freq_q, sq_freq_d;
  logic        sq_on_q, sq_on_d;
  logic [6:0]  sq_note_q, sq_note_d;
  logic [11:0] tri_freq_q, tri_freq_d;
  logic        tri_on_q, tri_on_d;
  logic [6:0]  tri_note_q, tri_note_d;
  logic        beat_q, beat_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Message decode helpers
  logic        exec3;
  logic [3:0]  msg;
  logic [3:0]  ch;
  logic [6:0]  d2;
  logic        note_on;
  logic        note_off;
  logic        all_off;
  logic        playable;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    d1_d         = d1_q;
    exec3        = 1'b0;
    msg          = status_q[7:4];
    ch           = status_q[3:0];
    d2           = rx_data[6:0];

    if (rx_valid) begin
      if (rx_data[7:3] == 5'b11111) begin
        // Real-time bytes are transparent to the parser.
      end else if (rx_data[7:4] == 4'hF) begin
        state_d  = IDLE;
        status_d = 8'h00;
      end else if (rx_data[7]) begin
        state_d  = WAIT_D1;
        status_d = rx_data;
      end else begin
        case (state_q)
          IDLE: begin
          end
          WAIT_D1: begin
            d1_d = rx_data[6:0];
            // Program change and channel pressure carry a single data byte.
            if (msg == 4'hC || msg == 4'hD) begin
              state_d = WAIT_D1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            exec3   = 1'b1;
            state_d = WAIT_D1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    note_on  = exec3 && (msg == 4'h9) && (d2 != 7'd0);
    note_off = exec3 && ((msg == 4'h8) || ((msg == 4'h9) && (d2 == 7'd0)));
    all_off  = exec3 && (msg == 4'hB) && (d1_q == 7'd123);
    playable = (d1_q <= 7'd107);

    ev_sq_on_d   = note_on && (ch == SQ_CH_L) && playable;
    ev_sq_off_d  = note_off && (ch == SQ_CH_L);
    ev_sq_all_d  = all_off && (ch == SQ_CH_L);
    ev_tri_on_d  = note_on && (ch == TRI_CH_L) && playable;
    ev_tri_off_d = note_off && (ch == TRI_CH_L);
    ev_tri_all_d = all_off && (ch == TRI_CH_L);
    ev_drum_d    = note_on && (ch == DRUM_CH_L);
    ev_note_d    = d1_q;
    ev_hz_d      = note_hz(d1_q);

    // Voices act one edge after the completing byte.
    sq_freq_d  = sq_freq_q;
    sq_on_d    = sq_on_q;
    sq_note_d  = sq_note_q;
    tri_freq_d = tri_freq_q;
    tri_on_d   = tri_on_q;
    tri_note_d = tri_note_q;

    if (ev_sq_on_q) begin
      sq_freq_d = ev_hz_q;
      sq_on_d   = 1'b1;
      sq_note_d = ev_note_q;
    end else if ((ev_sq_off_q && (ev_note_q == sq_note_q)) || ev_sq_all_q) begin
      sq_on_d = 1'b0;
    end

    if (ev_tri_on_q) begin
      tri_freq_d = ev_hz_q;
      tri_on_d   = 1'b1;
      tri_note_d = ev_note_q;
    end else if ((ev_tri_off_q && (ev_note_q == tri_note_q)) || ev_tri_all_q) begin
      tri_on_d = 1'b0;
    end

    beat_d     = beat_q;
    beat_cnt_d = beat_cnt_q;
    if (ev_drum_q) begin
      beat_d     = 1'b1;
      beat_cnt_d = BEAT_LOAD;
    end else if (beat_cnt_q != '0) begin
      beat_cnt_d = beat_cnt_q - BEAT_W'(1);
    end else begin
      beat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      status_q     <= 8'h00;
      d1_q         <= 7'd0;
      ev_sq_on_q   <= 1'b0;
      ev_sq_off_q  <= 1'b0;
      ev_sq_all_q  <= 1'b0;
      ev_tri_on_q  <= 1'b0;
      ev_tri_off_q <= 1'b0;
      ev_tri_all_q <= 1'b0;
      ev_drum_q    <= 1'b0;
      ev_note_q    <= 7'd0;
      ev_hz_q      <= HZ_A4;
      sq_freq_q    <= HZ_A4;
      sq_on_q      <= 1'b0;
      sq_note_q    <= NOTE_A4;
      tri_freq_q   <= HZ_A4;
      tri_on_q     <= 1'b0;
      tri_note_q   <= NOTE_A4;
      beat_q       <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      d1_q         <= d1_d;
      ev_sq_on_q   <= ev_sq_on_d;
      ev_sq_off_q  <= ev_sq_off_d;
      ev_sq_all_q  <= ev_sq_all_d;
      ev_tri_on_q  <= ev_tri_on_d;
      ev_tri_off_q <= ev_tri_off_d;
      ev_tri_all_q <= ev_tri_all_d;
      ev_drum_q    <= ev_drum_d;
      ev_note_q    <= ev_note_d;
      ev_hz_q      <= ev_hz_d;
      sq_freq_q    <= sq_freq_d;
      sq_on_q      <= sq_on_d;
      sq_note_q    <= sq_note_d;
      tri_freq_q   <= tri_freq_d;
      tri_on_q     <= tri_on_d;
      tri_note_q   <= tri_note_d;
      beat_q       <= beat_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign sq_freq  = sq_freq_q;
  assign sq_on    = sq_on_q;
  assign tri_freq = tri_freq_q;
  assign tri_on   = tri_on_q;
  assign beat     = beat_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb/tb_midi_note_decoder.sv - self-checking bench for midi_note_decoder
module tb_midi_note_decoder;

  localparam int BEAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] sq_freq;
  logic        sq_on;
  logic [11:0] tri_freq;
  logic        tri_on;
  logic        beat;

  midi_note_decoder #(
    .SQ_CH(0), .TRI_CH(1), .DRUM_CH(9), .BEAT_CYCLES(BEAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .sq_freq(sq_freq), .sq_on(sq_on), .tri_freq(tri_freq), .tri_on(tri_on),
    .beat(beat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_hz(input int n);
    return int'($floor(440.0 * $pow(2.0, real'(n - 69) / 12.0) + 0.5));
  endfunction

  bit m_live = 1'b0;
  int m_status = -1;
  int m_data[$];
  int e_sq_freq = 440, e_tri_freq = 440, e_sq_note = 69, e_tri_note = 69;
  bit e_sq_on = 1'b0, e_tri_on = 1'b0;
  int e_beat_left = 0;
  bit p_valid = 1'b0;
  int p_status, p_d1, p_d2;

  task automatic m_exec(input int st, input int d1, input int d2);
    int kind;
    int ch;
    kind = st / 16;
    ch   = st % 16;
    if (kind == 9 && d2 != 0) begin
      if (ch == 0 && d1 <= 107) begin e_sq_freq = model_hz(d1); e_sq_on = 1; e_sq_note = d1; end
      if (ch == 1 && d1 <= 107) begin e_tri_freq = model_hz(d1); e_tri_on = 1; e_tri_note = d1; end
      if (ch == 9) e_beat_left = BEAT;
    end else if (kind == 8 || kind == 9) begin
      if (ch == 0 && d1 == e_sq_note) e_sq_on = 0;
      if (ch == 1 && d1 == e_tri_note) e_tri_on = 0;
    end else if (kind == 11 && d1 == 123) begin
      if (ch == 0) e_sq_on = 0;
      if (ch == 1) e_tri_on = 0;
    end
  endtask

  task automatic m_take(input int b);
    int need;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin m_status = -1; m_data.delete(); return; end
    if (b >= 'h80) begin m_status = b; m_data.delete(); return; end
    if (m_status < 0) return;
    m_data.push_back(b);
    need = (m_status / 16 == 12 || m_status / 16 == 13) ? 1 : 2;
    if (m_data.size() == need) begin
      if (need == 2) begin
        p_valid = 1; p_status = m_status; p_d1 = m_data[0]; p_d2 = m_data[1];
      end
      m_data.delete();
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_live = 1; m_status = -1; m_data.delete(); p_valid = 0;
      e_sq_freq = 440; e_tri_freq = 440; e_sq_note = 69; e_tri_note = 69;
      e_sq_on = 0; e_tri_on = 0; e_beat_left = 0;
    end else begin
      if (e_beat_left > 0) e_beat_left--;
      if (p_valid) m_exec(p_status, p_d1, p_d2);
      p_valid = 0;
      if (rx_valid) m_take(int'(rx_data));
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model sq_freq", int'(sq_freq), e_sq_freq);
      check("model sq_on", int'(sq_on), int'(e_sq_on));
      check("model tri_freq", int'(tri_freq), e_tri_freq);
      check("model tri_on", int'(tri_on), int'(e_tri_on));
      check("model beat", int'(beat), (e_beat_left > 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  int msgs[9] = '{8, 9, 9, 9, 11, 12, 13, 14, 10};
  int chans[4] = '{0, 1, 9, 5};

  initial begin
    int r;
    int k;
    logic [7:0] b;

    step(3);
    reset_n = 1'b1;
    step(10);
    check("reset sq_freq", int'(sq_freq), 440);
    check("reset tri_freq", int'(tri_freq), 440);
    check("reset sq_on", int'(sq_on), 0);
    check("reset tri_on", int'(tri_on), 0);
    check("reset beat", int'(beat), 0);

    send3(8'h90, 8'h45, 8'h64);
    check("latency sq_on", int'(sq_on), 0);
    step(1);
    check("on sq_on", int'(sq_on), 1);
    check("on sq_freq", int'(sq_freq), 440);
    send3(8'h80, 8'h45, 8'h00); step(1);
    check("off sq_on", int'(sq_on), 0);
    check("off sq_freq", int'(sq_freq), 440);

    send3(8'h91, 8'h3C, 8'h40); step(1);
    check("tri c4 freq", int'(tri_freq), 262);
    check("tri c4 on", int'(tri_on), 1);
    send(8'h45); send(8'h40); step(1);
    check("tri rs freq", int'(tri_freq), 440);
    check("tri rs on", int'(tri_on), 1);
    send(8'h3C); send(8'h00); step(1);
    check("tri stale off", int'(tri_on), 1);
    send(8'h45); send(8'h00); step(1);
    check("tri off", int'(tri_on), 0);
    check("tri hold freq", int'(tri_freq), 440);

    send(8'h90); send(8'hF8); send(8'h51); send(8'hFE); send(8'h7F); step(1);
    check("rt sq_freq", int'(sq_freq), 880);
    check("rt sq_on", int'(sq_on), 1);

    send3(8'h99, 8'h24, 8'h7F);
    for (int i = 1; i <= 5; i++) begin
      step(1); check("beat pulse", int'(beat), (i <= 4) ? 1 : 0);
    end
    step(2);
    send3(8'h99, 8'h24, 8'h7F); step(1);
    send3(8'h99, 8'h24, 8'h7F);
    for (int i = 1; i <= 5; i++) begin
      step(1); check("beat retrigger", int'(beat), (i <= 4) ? 1 : 0);
    end

    send3(8'h90, 8'h45, 8'h40); step(1);
    send3(8'h90, 8'h6C, 8'h40); step(1);
    check("n108 freq", int'(sq_freq), 440);
    check("n108 on", int'(sq_on), 1);
    send3(8'h90, 8'h51, 8'h40); step(1);
    check("a5 freq", int'(sq_freq), 880);
    send3(8'h90, 8'h6C, 8'h40); step(1);
    check("n108 hold 880", int'(sq_freq), 880);
    send3(8'hF0, 8'h45, 8'h40); send3(8'hF7, 8'h45, 8'h40); step(1);
    check("sysex freq", int'(sq_freq), 880);
    check("sysex on", int'(sq_on), 1);
    send3(8'h90, 8'h45, 8'h40); send3(8'hB0, 8'h7B, 8'h00); step(1);
    check("all off sq_on", int'(sq_on), 0);

    send3(8'h90, 8'h51, 8'h7F); step(1);
    send(8'h90);
    reset_n = 1'b0; step(1); reset_n = 1'b1;
    send(8'h45); send(8'h40); step(2);
    check("mid reset freq", int'(sq_freq), 440);
    check("mid reset on", int'(sq_on), 0);

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        b = 8'hF8 + 8'($urandom_range(0, 7));
      end else if (r < 6) begin
        b = 8'hF0 + 8'($urandom_range(0, 7));
      end else if (r < 28) begin
        k = msgs[$urandom_range(0, 8)] * 16 + chans[$urandom_range(0, 3)];
        b = 8'(k);
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 50)      b = 8'($urandom_range(60, 70));
        else if (r < 70) b = 8'($urandom_range(100, 115));
        else if (r < 80) b = 8'h00;
        else if (r < 88) b = 8'd123;
        else             b = 8'($urandom_range(0, 127));
      end
      send(b);
      if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0; step(1); reset_n = 1'b1;
      end
    end
    step(10);

    check("model hz 21", model_hz(21), 28);
    check("model hz 57", model_hz(57), 220);
    check("model hz 60", model_hz(60), 262);
    check("model hz 69", model_hz(69), 440);
    check("model hz 81", model_hz(81), 880);
    check("model hz 107", model_hz(107), 3951);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
